// File: rtl/regfile_write_arbiter_if.sv
// Write-side bundle between the writeback stage, the debug loader and the register file.
// The arbiter uses the slave modport; the driving environment uses the master modport.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);
  logic              clear_req;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              dbg_valid;
  logic              dbg_ready;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              stall_req;
  logic              init_done;
  logic              proto_err;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport slave (
    input  clear_req, wb_en, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
    output dbg_ready, stall_req, init_done, proto_err, rf_we, rf_waddr, rf_wdata
  );

  modport master (
    output clear_req, wb_en, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready, stall_req, init_done, proto_err, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register file's single write port: clears every register after reset or on
// request, then arbitrates writeback against debug writes with a starvation-driven stall.
module regfile_write_arbiter #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       ADDR_W       = 5,
  parameter int unsigned       NUM_REGS     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
  parameter int unsigned       STARVE_LIMIT = 4
) (
  input logic                   clk,
  input logic                   rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  localparam logic [ADDR_W:0]    SweepEnd    = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W:0]    SweepOne    = (ADDR_W + 1)'(1);
  localparam logic [StarveW-1:0] StarveLimit = StarveW'(STARVE_LIMIT);
  localparam logic [StarveW-1:0] StarveOne   = StarveW'(1);

  typedef enum logic [1:0] {
    StInit,
    StRun,
    StStall
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     sweep_q, sweep_d;
  logic [StarveW-1:0]  starve_q, starve_d;

  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                stall_req_q, stall_req_d;
  logic                init_done_q, init_done_d;
  logic                proto_err_q, proto_err_d;
  logic                dbg_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      sweep_q     <= '0;
      starve_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      stall_req_q <= 1'b1;
      init_done_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      starve_q    <= starve_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_req_q <= stall_req_d;
      init_done_q <= init_done_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    starve_d   = starve_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    dbg_grant  = 1'b0;

    unique case (state_q)
      StInit: begin
        starve_d = '0;
        // One extra cycle at SweepEnd lets the last clear write land before RUN is advertised.
        if (sweep_q == SweepEnd) begin
          state_d = StRun;
        end else begin
          rf_we_d    = 1'b1;
          rf_waddr_d = sweep_q[ADDR_W-1:0];
          rf_wdata_d = INIT_VALUE;
          sweep_d    = sweep_q + SweepOne;
        end
      end

      StRun: begin
        if (bus.wb_en) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.wb_addr;
          rf_wdata_d = bus.wb_data;
        end else if (bus.dbg_valid) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.dbg_addr;
          rf_wdata_d = bus.dbg_data;
          dbg_grant  = 1'b1;
        end

        if (bus.dbg_valid && !dbg_grant) begin
          if (starve_q != StarveLimit) begin
            starve_d = starve_q + StarveOne;
          end
        end else begin
          starve_d = '0;
        end

        if (starve_d == StarveLimit) begin
          state_d = StStall;
        end
      end

      StStall: begin
        // A writeback that ignores the stall still wins so its data is never lost.
        if (bus.wb_en) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.wb_addr;
          rf_wdata_d = bus.wb_data;
        end else if (bus.dbg_valid) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = bus.dbg_addr;
          rf_wdata_d = bus.dbg_data;
          dbg_grant  = 1'b1;
        end
        starve_d = '0;
        state_d  = StRun;
      end

      default: begin
        state_d = StInit;
        sweep_d = '0;
      end
    endcase

    if (bus.clear_req) begin
      state_d  = StInit;
      sweep_d  = '0;
      starve_d = '0;
    end

    stall_req_d = (state_d != StRun);
    init_done_d = (state_d != StInit);
    proto_err_d = proto_err_q | (bus.wb_en & stall_req_q);
  end

  assign bus.dbg_ready = dbg_grant & ~rst;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.stall_req = stall_req_q;
  assign bus.init_done = init_done_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a cycle-level reference model checked every
// cycle, plus literal expectations for the init sweep, arbitration, stall and error cases.
module tb_regfile_write_arbiter;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ADDR_W       = 5;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam logic [DATA_W-1:0] INIT_VALUE = 8'h00;

  logic clk;
  logic rst;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  regfile_write_arbiter #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .NUM_REGS    (NUM_REGS),
    .INIT_VALUE  (INIT_VALUE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: sweep position (-1 = not sweeping), lost-cycle count, stall pending.
  bit m_valid = 1'b0;
  int m_sweep;
  int m_lost;
  bit m_stall;
  bit m_in_init;
  bit m_grant;
  bit e_we;
  int e_waddr;
  int e_wdata;
  bit e_stall;
  bit e_done;
  bit e_perr;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_sweep = 0;
      m_lost  = 0;
      m_stall = 1'b0;
      e_we    = 1'b0;
      e_waddr = 0;
      e_wdata = 0;
      e_stall = 1'b1;
      e_done  = 1'b0;
      e_perr  = 1'b0;
    end else if (m_valid) begin
      m_in_init = (m_sweep >= 0);
      m_grant   = !m_in_init && !bus_if.wb_en && bus_if.dbg_valid;
      e_perr    = e_perr || (bus_if.wb_en && e_stall);
      e_we      = 1'b0;
      if (m_in_init) begin
        if (m_sweep < int'(NUM_REGS)) begin
          e_we    = 1'b1;
          e_waddr = m_sweep;
          e_wdata = int'(INIT_VALUE);
          m_sweep = m_sweep + 1;
        end else begin
          m_sweep = -1;
        end
      end else if (bus_if.wb_en) begin
        e_we    = 1'b1;
        e_waddr = int'(bus_if.wb_addr);
        e_wdata = int'(bus_if.wb_data);
      end else if (bus_if.dbg_valid) begin
        e_we    = 1'b1;
        e_waddr = int'(bus_if.dbg_addr);
        e_wdata = int'(bus_if.dbg_data);
      end
      if (!m_in_init) begin
        if (m_stall) begin
          m_stall = 1'b0;
          m_lost  = 0;
        end else begin
          m_lost = (bus_if.dbg_valid && !m_grant) ? m_lost + 1 : 0;
          if (m_lost == int'(STARVE_LIMIT)) m_stall = 1'b1;
        end
      end
      if (bus_if.clear_req) begin
        m_sweep = 0;
        m_lost  = 0;
        m_stall = 1'b0;
      end
      e_stall = (m_sweep >= 0) || m_stall;
      e_done  = (m_sweep < 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp rf_we", bus_if.rf_we, e_we);
      chk("cmp stall_req", bus_if.stall_req, e_stall);
      chk("cmp init_done", bus_if.init_done, e_done);
      chk("cmp proto_err", bus_if.proto_err, e_perr);
      chk("cmp dbg_ready", bus_if.dbg_ready,
          !rst && (m_sweep < 0) && !bus_if.wb_en && bus_if.dbg_valid);
      if (e_we) begin
        chk("cmp rf_waddr", bus_if.rf_waddr, e_waddr);
        chk("cmp rf_wdata", bus_if.rf_wdata, e_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string name, input int addr, input int data);
    chk({name, " we"}, bus_if.rf_we, 1);
    chk({name, " addr"}, bus_if.rf_waddr, addr);
    chk({name, " data"}, bus_if.rf_wdata, data);
  endtask

  task automatic chk_sweep(input string name);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      step();
      chk_write($sformatf("%s sweep[%0d]", name, i), i, 0);
      chk($sformatf("%s init_done[%0d]", name, i), bus_if.init_done, 0);
    end
    step();
    chk({name, " init_done after sweep"}, bus_if.init_done, 1);
    chk({name, " stall_req after sweep"}, bus_if.stall_req, 0);
    chk({name, " idle after sweep"}, bus_if.rf_we, 0);
  endtask

  initial begin
    rst              = 1'b1;
    bus_if.clear_req = 1'b0;
    bus_if.wb_en     = 1'b0;
    bus_if.wb_addr   = '0;
    bus_if.wb_data   = '0;
    bus_if.dbg_valid = 1'b0;
    bus_if.dbg_addr  = '0;
    bus_if.dbg_data  = '0;

    // Reset values, then full init sweep.
    step();
    step();
    chk("reset rf_we", bus_if.rf_we, 0);
    chk("reset rf_waddr", bus_if.rf_waddr, 0);
    chk("reset rf_wdata", bus_if.rf_wdata, 0);
    chk("reset stall_req", bus_if.stall_req, 1);
    chk("reset init_done", bus_if.init_done, 0);
    chk("reset proto_err", bus_if.proto_err, 0);
    chk("reset dbg_ready", bus_if.dbg_ready, 0);
    rst = 1'b0;
    chk_sweep("init");

    // Writeback only.
    bus_if.wb_en   = 1'b1;
    bus_if.wb_addr = 5'd7;
    bus_if.wb_data = 8'hA5;
    #1 chk("wb dbg_ready", bus_if.dbg_ready, 0);
    step();
    bus_if.wb_en = 1'b0;
    chk_write("wb", 7, 'hA5);

    // Debug only.
    bus_if.dbg_valid = 1'b1;
    bus_if.dbg_addr  = 5'd3;
    bus_if.dbg_data  = 8'h3C;
    #1 chk("dbg dbg_ready", bus_if.dbg_ready, 1);
    step();
    bus_if.dbg_valid = 1'b0;
    chk_write("dbg", 3, 'h3C);

    // Starvation: four lost cycles raise stall_req, then debug wins in the stall cycle.
    bus_if.wb_en     = 1'b1;
    bus_if.wb_addr   = 5'd1;
    bus_if.wb_data   = 8'h11;
    bus_if.dbg_valid = 1'b1;
    bus_if.dbg_addr  = 5'd9;
    bus_if.dbg_data  = 8'h99;
    for (int i = 0; i < 3; i++) step();
    chk("starve stall_req early", bus_if.stall_req, 0);
    step();
    chk("starve stall_req", bus_if.stall_req, 1);
    bus_if.wb_en = 1'b0;
    #1 chk("starve dbg_ready", bus_if.dbg_ready, 1);
    step();
    chk_write("starve grant", 9, 'h99);
    chk("starve stall released", bus_if.stall_req, 0);
    chk("starve no proto_err", bus_if.proto_err, 0);

    // Starve again from zero; this time writeback ignores the stall.
    bus_if.wb_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("restarve stall_req early", bus_if.stall_req, 0);
    step();
    chk("restarve stall_req", bus_if.stall_req, 1);
    bus_if.wb_addr = 5'd2;
    bus_if.wb_data = 8'h22;
    #1 chk("proto dbg_ready", bus_if.dbg_ready, 0);
    step();
    bus_if.wb_en     = 1'b0;
    bus_if.dbg_valid = 1'b0;
    chk_write("proto wb", 2, 'h22);
    chk("proto_err set", bus_if.proto_err, 1);
    step();
    step();
    chk("proto_err sticky", bus_if.proto_err, 1);

    // clear_req with a same-cycle writeback, then reset at sweep address 10.
    bus_if.clear_req = 1'b1;
    bus_if.wb_en     = 1'b1;
    bus_if.wb_addr   = 5'd5;
    bus_if.wb_data   = 8'h55;
    step();
    bus_if.clear_req = 1'b0;
    bus_if.wb_en     = 1'b0;
    chk_write("clear wb", 5, 'h55);
    chk("clear init_done", bus_if.init_done, 0);
    chk("clear stall_req", bus_if.stall_req, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_write($sformatf("clear sweep[%0d]", i), i, 0);
    end
    chk("clear proto_err kept", bus_if.proto_err, 1);
    rst = 1'b1;
    step();
    chk("midsweep rst rf_we", bus_if.rf_we, 0);
    chk("midsweep rst proto_err", bus_if.proto_err, 0);
    chk("midsweep rst init_done", bus_if.init_done, 0);
    rst = 1'b0;
    chk_sweep("resweep");

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sequencer and arbiter for the shared write port of the 32 x 8 register file. After reset (or on request) it clears every register to a programmable value. It then shares the single write port between the pipeline writeback stage and a debug/loader requester, with a starvation guard that briefly stalls the pipeline. It sits between the writeback stage, the debug loader and the register file's write inputs, and drives the register file's write-enable, write-address and write-data.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, registers cleared by the init sweep (≤ 2^ADDR_W)
- INIT_VALUE, 0, value written to every register during init
- STARVE_LIMIT, 4, consecutive cycles a pending debug write may lose before stall is requested (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- clear_req  in  1  pulse: re-run init sweep
- wb_en  in  1  writeback write request (no backpressure)
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- dbg_valid  in  1  debug write request
- dbg_ready  out  1  debug write accepted this cycle
- dbg_addr  in  ADDR_W  debug destination
- dbg_data  in  DATA_W  debug data
- stall_req  out  1  pipeline must hold writeback (wb_en=0) while high
- init_done  out  1  init sweep complete
- proto_err  out  1  sticky: wb_en seen while stall_req high
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data

## Operation
- FSM states: INIT, RUN, STALL.
- INIT:
  - Sweep counter 0..NUM_REGS-1, one write per cycle of INIT_VALUE.
  - stall_req=1, dbg_ready=0, init_done=0; wb_en is ignored (and flags proto_err).
  - After writing NUM_REGS-1, go to RUN.
- RUN:
  - wb_en=1 wins: write wb_addr/wb_data; dbg_ready=0.
  - Else if dbg_valid=1: write dbg_addr/dbg_data; dbg_ready=1.
  - Starve counter increments each cycle dbg_valid=1 and dbg_ready=0. It clears on a grant or when dbg_valid=0.
  - When the counter reaches STARVE_LIMIT, go to STALL.
- STALL:
  - stall_req=1. Debug is granted if dbg_valid; otherwise nothing is written.
  - Next cycle return to RUN and clear the starve counter.
  - If wb_en=1 in STALL: wb still wins (data never dropped), proto_err sets, dbg not granted.
- clear_req=1 in any state: next state INIT, sweep counter 0, init_done=0. A request present in that same cycle is still arbitrated normally.
- Write ordering between wb and dbg to the same address follows grant order; there is no merging.
- Counter widths: sweep counter is ADDR_W+1 bits; starve counter is $clog2(STARVE_LIMIT+1) bits and saturates.

## Timing
- rf_we/rf_waddr/rf_wdata are registered: a write arbitrated in cycle n appears on the outputs in cycle n+1. The register file commits on its own edge in that cycle.
- dbg_ready is combinational from state and inputs, valid in the arbitration cycle. The handshake completes when dbg_valid and dbg_ready are both 1 at a rising edge.
- stall_req and init_done are registered, decoded from state.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, proto_err=0, init_done=0, stall_req=1, dbg_ready=0.
  - State INIT, sweep counter 0, starve counter 0.
- Init latency: first init write is on the outputs 1 cycle after rst deasserts, last after NUM_REGS cycles. init_done=1 and stall_req=0 from cycle NUM_REGS+1.
- rst mid-sweep or mid-STALL restarts the sweep at address 0 with no partial outputs.
- proto_err clears only on rst.

## Test plan
- Reset then idle: hold rst 2 cycles, release → rf_we=1 for 32 cycles with rf_waddr 0..31, rf_wdata=0; init_done=1 and stall_req=0 on cycle 33.
- Writeback only: wb_en=1, addr 7, data 0xA5 → next cycle rf_we=1, rf_waddr=7, rf_wdata=0xA5; dbg_ready=0 throughout.
- Debug only: dbg_valid=1, addr 3, data 0x3C, wb_en=0 → dbg_ready=1 same cycle; next cycle rf_waddr=3, rf_wdata=0x3C.
- Starvation: wb_en=1 continuously and dbg_valid=1 → after 4 lost cycles stall_req=1; the bench drops wb_en → dbg granted, then stall_req=0 and the starve counter is 0.
- Protocol violation: keep wb_en=1 during STALL → wb write still appears on the outputs, proto_err=1 and stays 1 until rst.
- clear_req mid-run after writes, plus rst asserted at sweep address 10 → sweep restarts at 0, init_done drops, 32 clear writes follow.
